mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words of backing storage (power of two, 4..4096).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, meaning wait states between request acceptance and response (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port mem_read, input, 1 bit: load request from the multicycle controller.
REQ-006 The block SHALL have port mem_write, input, 1 bit: store request from the multicycle controller.
REQ-007 The block SHALL have port addr, input, 32 bits: byte address.
REQ-008 The block SHALL have port wdata, input, 32 bits: store data, right-aligned.
REQ-009 The block SHALL have port funct3, input, 3 bits: RV32I access size/sign field.
REQ-010 The block SHALL have port rdata, output, 32 bits: load result, extended to 32 bits.
REQ-011 The block SHALL have port mem_ready, output, 1 bit: one-cycle response strobe.
REQ-012 The block SHALL have port mem_err, output, 1 bit: access fault, valid only while mem_ready=1.

Function
REQ-013 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE, exactly one of mem_read/mem_write high SHALL latch addr, wdata, funct3 and request type; the FSM SHALL go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-015 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; the FSM SHALL go to RESP when it reaches 0.
REQ-016 In RESP, mem_ready SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-017 Response latency SHALL be WAIT_CYCLES+1 cycles from the accepting edge to mem_ready high.
REQ-018 Request inputs SHALL be ignored outside IDLE; changes during WAIT/RESP SHALL not affect the in-flight access.
REQ-019 mem_read and mem_write both high in IDLE SHALL be accepted as a faulting access: mem_err=1 at RESP, no store, rdata=0.
REQ-020 Loads SHALL decode funct3 as 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; byte/half lane SHALL be selected by addr[1:0].
REQ-021 Stores SHALL decode funct3 as 000 SB, 001 SH, 010 SW, writing only the addressed byte lanes, on the clock edge that ends RESP.
REQ-022 An unsupported funct3, or addr >= DEPTH_WORDS*4, SHALL give mem_err=1, rdata=0 and no store.
REQ-023 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-024 rdata SHALL be 0 whenever mem_ready=0.
REQ-025 A new request held high across RESP SHALL be accepted in the IDLE cycle that follows, with no back-to-back acceptance.

Reset
REQ-026 Asserting rst low SHALL immediately force state IDLE, counter 0, mem_ready=0, mem_err=0, rdata=0.
REQ-027 Reset mid-access SHALL abort the access with no store performed.
REQ-028 Storage contents SHALL not be cleared by reset.

Configuration
REQ-029 With macro MEM_MISALIGN_TRAP_EN defined, misaligned halfword (addr[0]=1) or word (addr[1:0]!=0) accesses SHALL give mem_err=1, rdata=0 and no store.
REQ-030 Without MEM_MISALIGN_TRAP_EN, misaligned accesses SHALL be serviced with addr[0] forced to 0 for halfwords and addr[1:0] forced to 0 for words, with no error.

Verification
REQ-031 SW 0xDEADBEEF to 0x10, then LW 0x10 with WAIT_CYCLES=1 -> mem_ready on the 2nd cycle after acceptance, rdata=0xDEADBEEF, mem_err=0.
REQ-032 SB 0x80 to 0x11, then LB 0x11 -> rdata=0xFFFFFF80; LBU 0x11 -> rdata=0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-033 LW at addr=DEPTH_WORDS*4 -> mem_err=1 and rdata=0; a following LW 0x10 is unaffected.
REQ-034 With WAIT_CYCLES=0, hold mem_read=1 continuously -> mem_ready pulses every 2nd cycle.
REQ-035 Assert rst low during WAIT of an SW to 0x20 -> outputs 0 immediately and a later LW 0x20 returns the prior contents.
REQ-036 LH at 0x13: with MEM_MISALIGN_TRAP_EN -> mem_err=1; without it -> halfword at 0x12 returned, mem_err=0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: RV32I data-memory responder; mem_ready pulses WAIT_CYCLES+1 cycles after acceptance, no backpressure (requests ignored while busy).
// Define MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them down.
module mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic        mem_ready,
   output logic        mem_err
);
   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [AW-1:0] word_idx;
   logic [31:0]   word;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic [31:0]   load_val;
   logic [31:0]   wr_word;
   logic          is_half, is_word, f3_ok, range_ok, align_ok, acc_err, wr_en;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               addr_d   = addr;
               wdata_d  = wdata;
               funct3_d = funct3;
               rd_d     = mem_read;
               wr_d     = mem_write;
               cnt_d    = WAIT_LOAD;
               state_d  = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         funct3_q <= 3'd0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
      end
   end

   assign word_idx = addr_q[AW+1:2];
   assign word     = mem_q[word_idx];

   always_comb begin
      is_half  = (funct3_q[1:0] == 2'b01);
      is_word  = (funct3_q[1:0] == 2'b10);
      // Stores accept only 000/001/010; loads additionally the unsigned 100/101.
      if (wr_q) f3_ok = !funct3_q[2] && (funct3_q[1:0] != 2'b11);
      else      f3_ok = (funct3_q[1:0] != 2'b11) && !(funct3_q[2] && funct3_q[1]);
      range_ok = (addr_q < MEM_BYTES);
`ifdef MEM_MISALIGN_TRAP_EN
      align_ok = !((is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00)));
`else
      align_ok = 1'b1;
`endif
      acc_err  = (rd_q && wr_q) || !f3_ok || !range_ok || !align_ok;
   end

   always_comb begin
      byte_v = word[{addr_q[1:0], 3'b000} +: 8];
      half_v = addr_q[1] ? word[31:16] : word[15:0];
      case (funct3_q)
         3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
         3'b001:  load_val = {{16{half_v[15]}}, half_v};
         3'b100:  load_val = {24'd0, byte_v};
         3'b101:  load_val = {16'd0, half_v};
         default: load_val = word;
      endcase
   end

   assign mem_ready = (state_q == RESP);
   assign mem_err   = mem_ready && acc_err;
   assign rdata     = (mem_ready && rd_q && !acc_err) ? load_val : 32'd0;

   // Read-modify-write of the addressed word; only the selected lanes change.
   always_comb begin
      wr_word = word;
      if (is_word) begin
         wr_word = wdata_q;
      end else if (is_half) begin
         if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
         else           wr_word[15:0]  = wdata_q[15:0];
      end else begin
         wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      wr_en = mem_ready && wr_q && !acc_err;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[word_idx] <= wr_word;
   end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 1/0/3) checked against a byte-array reference model.
`timescale 1ns/1ps
module tb_mem_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  rd_i, wr_i;
   logic [31:0] a_i [3];
   logic [31:0] wd_i [3];
   logic [2:0]  f3_i [3];
   logic [31:0] rdata_o [3];
   logic [2:0]  rdy_o, err_o;

   logic [7:0]  ref_mem [3][1024];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut0 (
      .clk(clk), .rst(rst), .mem_read(rd_i[0]), .mem_write(wr_i[0]), .addr(a_i[0]),
      .wdata(wd_i[0]), .funct3(f3_i[0]), .rdata(rdata_o[0]), .mem_ready(rdy_o[0]), .mem_err(err_o[0]));
   mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut1 (
      .clk(clk), .rst(rst), .mem_read(rd_i[1]), .mem_write(wr_i[1]), .addr(a_i[1]),
      .wdata(wd_i[1]), .funct3(f3_i[1]), .rdata(rdata_o[1]), .mem_ready(rdy_o[1]), .mem_err(err_o[1]));
   mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(3)) u_dut2 (
      .clk(clk), .rst(rst), .mem_read(rd_i[2]), .mem_write(wr_i[2]), .addr(a_i[2]),
      .wdata(wd_i[2]), .funct3(f3_i[2]), .rdata(rdata_o[2]), .mem_ready(rdy_o[2]), .mem_err(err_o[2]));

   function automatic int wait_of(input int sel);
      return (sel == 0) ? 1 : (sel == 1) ? 0 : 3;
   endfunction

   function automatic int depth_of(input int sel);
      return (sel == 0) ? 256 : 16;
   endfunction

   // Reference: byte-addressed memory, access size from funct3, error rules applied first.
   task automatic model(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output logic [31:0] er, output logic ee);
      int size;
      bit bad;
      logic [31:0] ea, v;
      er = 32'd0;
      ee = 1'b0;
      case (f3)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default:        size = 0;
      endcase
      bad = (rd && wr) || (size == 0) || (wr && f3[2]) || (a >= 32'(depth_of(sel) * 4));
`ifdef MEM_MISALIGN_TRAP_EN
      if (size > 1 && (a & 32'(size - 1)) != 32'd0) bad = 1'b1;
`endif
      if (bad) begin
         ee = 1'b1;
         return;
      end
      ea = a & ~32'(size - 1);
      if (wr) begin
         for (int i = 0; i < size; i++) ref_mem[sel][ea + 32'(i)] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[sel][ea + 32'(i)];
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
         er = v;
      end
   endtask

   task automatic drive(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3);
      rd_i[sel] = rd;
      wr_i[sel] = wr;
      a_i[sel]  = a;
      wd_i[sel] = wd;
      f3_i[sel] = f3;
   endtask

   // One access; inputs are scrambled while busy, and outputs must stay quiet until the strobe.
   task automatic xact(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3,
                       output logic [31:0] gr, output logic ge, output int lat, output bit leak);
      gr = 32'd0; ge = 1'b0; lat = 0; leak = 1'b0;
      @(negedge clk);
      drive(sel, rd, wr, a, wd, f3);
      @(posedge clk);
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         #1;
         if (rdy_o[sel] === 1'b1) begin
            lat = k;
            gr  = rdata_o[sel];
            ge  = err_o[sel];
            drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
         end else begin
            if (rdata_o[sel] !== 32'd0 || err_o[sel] !== 1'b0) leak = 1'b1;
            drive(sel, 1'($urandom), 1'($urandom), $urandom, $urandom, 3'($urandom));
            @(posedge clk);
         end
      end
      if (lat == 0) begin
         drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      end else begin
         @(posedge clk);
         #1;
         if (rdy_o[sel] !== 1'b0) leak = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         n_checks++;
         if (rdy_o[s] !== 1'b0 || err_o[s] !== 1'b0 || rdata_o[s] !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_outputs dut%0d: ready=%b err=%b rdata=%h, want 0/0/0", s, rdy_o[s], err_o[s], rdata_o[s]);
         end
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_init(input int sel);
      logic [31:0] wd, er, gr;
      logic ee, ge;
      int lat;
      bit leak;
      for (int w = 0; w < depth_of(sel); w++) begin
         wd = $urandom;
         model(sel, 1'b0, 1'b1, 32'(w * 4), wd, 3'b010, er, ee);
         xact(sel, 1'b0, 1'b1, 32'(w * 4), wd, 3'b010, gr, ge, lat, leak);
         n_checks++;
         if (ge !== 1'b0 || lat != wait_of(sel) + 1) begin
            n_errors++;
            $display("FAIL init_sw dut%0d word %0d: err=%b lat=%0d, want 0/%0d", sel, w, ge, lat, wait_of(sel) + 1);
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] er, gr;
      logic ee, ge;
      int lat;
      bit leak;
      model(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, er, ee);
      xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, gr, ge, lat, leak);
      n_checks++;
      if (ge !== 1'b0) begin n_errors++; $display("FAIL sw_10 err=%b want 0", ge); end

      xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, gr, ge, lat, leak);
      n_checks++;
      if (lat != 2 || gr !== 32'hDEADBEEF || ge !== 1'b0) begin
         n_errors++;
         $display("FAIL lw_10 lat=%0d rdata=%h err=%b, want 2/deadbeef/0", lat, gr, ge);
      end

      model(0, 1'b0, 1'b1, 32'h11, 32'h80, 3'b000, er, ee);
      xact(0, 1'b0, 1'b1, 32'h11, 32'h80, 3'b000, gr, ge, lat, leak);
      xact(0, 1'b1, 1'b0, 32'h11, 32'h0, 3'b000, gr, ge, lat, leak);
      n_checks++;
      if (gr !== 32'hFFFFFF80 || ge !== 1'b0) begin n_errors++; $display("FAIL lb_11 rdata=%h err=%b, want ffffff80/0", gr, ge); end
      xact(0, 1'b1, 1'b0, 32'h11, 32'h0, 3'b100, gr, ge, lat, leak);
      n_checks++;
      if (gr !== 32'h00000080 || ge !== 1'b0) begin n_errors++; $display("FAIL lbu_11 rdata=%h err=%b, want 00000080/0", gr, ge); end
      xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, gr, ge, lat, leak);
      n_checks++;
      if (gr !== 32'hDEAD80EF) begin n_errors++; $display("FAIL lw_after_sb rdata=%h, want dead80ef", gr); end

      xact(0, 1'b1, 1'b0, 32'd1024, 32'h0, 3'b010, gr, ge, lat, leak);
      n_checks++;
      if (ge !== 1'b1 || gr !== 32'd0) begin n_errors++; $display("FAIL lw_oob err=%b rdata=%h, want 1/00000000", ge, gr); end
      xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, gr, ge, lat, leak);
      n_checks++;
      if (gr !== 32'hDEAD80EF || ge !== 1'b0) begin n_errors++; $display("FAIL lw_after_oob rdata=%h err=%b, want dead80ef/0", gr, ge); end

      xact(0, 1'b1, 1'b0, 32'h13, 32'h0, 3'b001, gr, ge, lat, leak);
      n_checks++;
`ifdef MEM_MISALIGN_TRAP_EN
      if (ge !== 1'b1 || gr !== 32'd0) begin n_errors++; $display("FAIL lh_13 err=%b rdata=%h, want 1/00000000", ge, gr); end
`else
      if (ge !== 1'b0 || gr !== 32'hFFFFDEAD) begin n_errors++; $display("FAIL lh_13 err=%b rdata=%h, want 0/ffffdead", ge, gr); end
`endif
   endtask

   task automatic test_random(input int sel, input int n);
      logic [31:0] a, wd, er, gr;
      logic [2:0] f3;
      logic rd, wr, ee, ge;
      int lat, kind, pick;
      bit leak;
      for (int t = 0; t < n; t++) begin
         kind = $urandom_range(0, 19);
         rd = (kind < 9) || (kind >= 18);
         wr = (kind >= 9);
         case ($urandom_range(0, 9))
            0:       a = 32'(depth_of(sel) * 4) + $urandom_range(0, 63);
            1:       a = $urandom;
            default: a = $urandom_range(0, depth_of(sel) * 4 - 1);
         endcase
         if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
         else begin
            pick = $urandom_range(0, 4);
            f3 = 3'((pick < 3) ? pick : pick + 1);
         end
         wd = $urandom;
         model(sel, rd, wr, a, wd, f3, er, ee);
         xact(sel, rd, wr, a, wd, f3, gr, ge, lat, leak);
         n_checks++;
         if (lat != wait_of(sel) + 1 || ge !== ee || gr !== er || leak) begin
            n_errors++;
            $display("FAIL rand dut%0d rd=%b wr=%b a=%h f3=%b: lat=%0d err=%b rdata=%h leak=%b, want %0d/%b/%h/0",
                     sel, rd, wr, a, f3, lat, ge, gr, leak, wait_of(sel) + 1, ee, er);
         end
      end
   endtask

   // Read held high: strobe every WAIT_CYCLES+2 cycles, never back to back.
   task automatic test_back_to_back(input int sel);
      logic [31:0] a, er;
      logic ee, exp_rdy;
      int period;
      period = wait_of(sel) + 2;
      a = 32'($urandom_range(0, depth_of(sel) - 1) * 4);
      model(sel, 1'b1, 1'b0, a, 32'd0, 3'b010, er, ee);
      @(negedge clk);
      drive(sel, 1'b1, 1'b0, a, 32'd0, 3'b010);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         exp_rdy = ((k % period) == period - 1);
         n_checks++;
         if (rdy_o[sel] !== exp_rdy || rdata_o[sel] !== (exp_rdy ? er : 32'd0)) begin
            n_errors++;
            $display("FAIL b2b dut%0d cycle %0d: ready=%b rdata=%h, want %b/%h", sel, k, rdy_o[sel], rdata_o[sel], exp_rdy, exp_rdy ? er : 32'd0);
         end
      end
      drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      repeat (wait_of(sel) + 3) @(posedge clk);
   endtask

   task automatic test_reset_abort();
      logic [31:0] prior, er, gr;
      logic ee, ge;
      int lat;
      bit leak;
      model(0, 1'b1, 1'b0, 32'h20, 32'd0, 3'b010, prior, ee);
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 32'h20, ~prior, 3'b010);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      rst = 1'b0;
      #1;
      n_checks++;
      if (rdy_o[0] !== 1'b0 || err_o[0] !== 1'b0 || rdata_o[0] !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_in_wait ready=%b err=%b rdata=%h, want 0/0/0", rdy_o[0], err_o[0], rdata_o[0]);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      xact(0, 1'b1, 1'b0, 32'h20, 32'd0, 3'b010, gr, ge, lat, leak);
      n_checks++;
      if (gr !== prior || ge !== 1'b0 || lat != 2) begin
         n_errors++;
         $display("FAIL aborted_store lw_20 rdata=%h err=%b lat=%0d, want %h/0/2", gr, ge, lat, prior);
      end
   endtask

   // Reset while the response strobe is high must clear it without waiting for a clock.
   task automatic test_reset_in_resp(input logic rd, input logic wr, input logic [31:0] a);
      logic [31:0] er;
      logic ee;
      model(0, rd, wr, a, 32'd0, 3'b010, er, ee);
      @(negedge clk);
      drive(0, rd, wr, a, 32'd0, 3'b010);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      @(posedge clk);
      #1;
      n_checks++;
      if (rdy_o[0] !== 1'b1 || err_o[0] !== ee || rdata_o[0] !== er) begin
         n_errors++;
         $display("FAIL resp_before_reset ready=%b err=%b rdata=%h, want 1/%b/%h", rdy_o[0], err_o[0], rdata_o[0], ee, er);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (rdy_o[0] !== 1'b0 || err_o[0] !== 1'b0 || rdata_o[0] !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_in_resp ready=%b err=%b rdata=%h, want 0/0/0", rdy_o[0], err_o[0], rdata_o[0]);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      for (int s = 0; s < 3; s++) test_init(s);
      test_directed();
      test_random(0, 250);
      test_random(1, 120);
      test_random(2, 120);
      for (int s = 0; s < 3; s++) test_back_to_back(s);
      test_reset_abort();
      test_reset_in_resp(1'b1, 1'b0, 32'h10);
      test_reset_in_resp(1'b1, 1'b1, 32'h10);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
